// File: rtl/seq_muldiv_alu.sv
// RV32 execute unit: single-cycle base ALU plus an iterative radix-2 multiply/divide
// engine (one bit per cycle), both behind valid/ready handshakes.
module seq_muldiv_alu #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_sel,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state, w_state_nx;
  logic [SHW-1:0]  r_count;
  logic [XLEN-1:0] r_alu_out;
  logic [XLEN-1:0] w_base_res, w_fast_res, w_m_res;
  logic [SHW-1:0]  w_shamt;
  logic            w_accept, w_last, w_m_op, w_div_zero, w_div_ovf, w_fast, w_iter;

  assign w_shamt    = dataB[SHW-1:0];
  assign w_accept   = in_valid && (r_state == S_IDLE) && !flush;
  assign w_last     = (r_count == SHW'(XLEN - 1));
  assign w_m_op     = ENABLE_M && (alu_sel[4:3] == 2'b10);
  assign w_div_zero = (dataB == '0);
  assign w_div_ovf  = !alu_sel[0] && (dataA == {1'b1, {(XLEN-1){1'b0}}}) && (&dataB);
  assign w_fast     = w_m_op && alu_sel[2] && (w_div_zero || w_div_ovf);
  assign w_iter     = w_m_op && !w_fast;

  // Divide-by-zero and signed-overflow results are known at issue; bypass the engine.
  assign w_fast_res = alu_sel[1] ? (w_div_zero ? dataA : '0)
                                 : (w_div_zero ? '1 : dataA);

  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    w_base_res = '0;
    case (alu_sel)
      5'b00000: w_base_res = dataA + dataB;
      5'b00001: w_base_res = dataA - dataB;
      5'b00010: w_base_res = dataA << w_shamt;
      5'b00011: w_base_res[0] = $signed(dataA) < $signed(dataB);
      5'b00100: w_base_res[0] = dataA < dataB;
      5'b00101: w_base_res = dataA ^ dataB;
      5'b00110: w_base_res = dataA >> w_shamt;
      5'b00111: w_base_res = $unsigned($signed(dataA) >>> w_shamt);
      5'b01000: w_base_res = dataA | dataB;
      5'b01001: w_base_res = dataA & dataB;
      5'b01011: w_base_res = dataB;
      default:  w_base_res = '0;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nx = w_iter ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_state_nx = S_DONE;
      S_DONE:  if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    // Abort wins over any same-cycle accept or retire.
    if (flush) w_state_nx = S_IDLE;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_alu_out <= '0;
    end else begin
      r_state <= w_state_nx;
      r_count <= (r_state == S_BUSY && !flush && !w_last) ? r_count + 1'b1 : '0;
      if (w_accept && !w_iter)
        r_alu_out <= w_fast ? w_fast_res : w_base_res;
      else if (r_state == S_BUSY && w_last && !flush)
        r_alu_out <= w_m_res;
    end
  end

  if (ENABLE_M) begin : g_m
    logic [XLEN-1:0]   r_hi, r_lo, r_b;
    logic              r_div, r_rem, r_upper, r_neg;
    logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN:0]     w_sum, w_rem_sh, w_diff;
    logic [XLEN-1:0]   w_hi_nx, w_lo_nx;
    logic [2*XLEN-1:0] w_prod;

    assign w_a_sgn = alu_sel[2] ? !alu_sel[0] : (alu_sel[1:0] == 2'b01 || alu_sel[1:0] == 2'b10);
    assign w_b_sgn = alu_sel[2] ? !alu_sel[0] : (alu_sel[1:0] == 2'b01);
    assign w_a_neg = w_a_sgn && dataA[XLEN-1];
    assign w_b_neg = w_b_sgn && dataB[XLEN-1];

    // NOTE: no reset here; these are always loaded at accept before being read.
    always_ff @(posedge clk) begin
      if (w_accept && w_iter) begin
        r_hi    <= '0;
        r_lo    <= w_a_neg ? -dataA : dataA;
        r_b     <= w_b_neg ? -dataB : dataB;
        r_div   <= alu_sel[2];
        r_rem   <= alu_sel[2] && alu_sel[1];
        r_upper <= (alu_sel[1:0] != 2'b00);
        r_neg   <= (alu_sel[2] && alu_sel[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
      end else if (r_state == S_BUSY) begin
        r_hi <= w_hi_nx;
        r_lo <= w_lo_nx;
      end
    end

    // Multiply: shift-add with r_lo as multiplier. Divide: restoring, r_lo collects quotient.
    always_comb begin
      w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_rem_sh = {r_hi, r_lo[XLEN-1]};
      w_diff   = w_rem_sh - {1'b0, r_b};
      if (r_div) begin
        w_hi_nx = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
        w_lo_nx = {r_lo[XLEN-2:0], !w_diff[XLEN]};
      end else begin
        w_hi_nx = w_sum[XLEN:1];
        w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
      end
      // Low half of a negated {hi,lo} equals the negated low half, so this also signs the quotient.
      w_prod = {w_hi_nx, w_lo_nx};
      if (r_neg) w_prod = -w_prod;
      if (!r_div)     w_m_res = r_upper ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
      else if (r_rem) w_m_res = r_neg ? -w_hi_nx : w_hi_nx;
      else            w_m_res = w_prod[XLEN-1:0];
    end
  end else begin : g_no_m
    assign w_m_res = '0;
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign alu_out   = r_alu_out;
endmodule

// File: tb/tb_seq_muldiv_alu.sv
// Scoreboard bench for seq_muldiv_alu: expected results are queued at issue and
// compared when the unit presents them; latency and handshake behaviour checked inline.
module tb_seq_muldiv_alu;
  localparam int XLEN = 32;
  localparam int MLAT = XLEN + 1;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [4:0]  alu_sel = '0;
  logic [31:0] dataA = '0, dataB = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] alu_out;

  seq_muldiv_alu #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .dataA(dataA), .dataB(dataB), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Present one op for exactly one edge; the unit must be idle when called.
  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input bit track);
    exp_t e;
    in_valid = 1'b1; alu_sel = sel; dataA = a; dataB = b;
    if (track) begin
      e.sel = sel; e.a = a; e.b = b; e.res = res; e.lat = lat;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; alu_sel = 5'($urandom); dataA = $urandom; dataB = $urandom;
  endtask

  // Wait (bounded) for out_valid, report what the unit shows, then retire it.
  task automatic collect(output logic [31:0] res, output int lat, output bit seen);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    seen = out_valid;
    res  = alu_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset busy: got %b want 0", busy); end
    n_checks++;
    if (alu_out !== 32'h0) begin n_errors++; $display("FAIL reset alu_out: got %h want 0", alu_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_base_ops();
    logic [4:0]  sel[16];
    logic [31:0] a[16], b[16], r[16], got;
    int lat; bit seen; exp_t e;
    sel = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00011, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01011, 5'b01111, 5'b01010, 5'b11000, 5'b00010};
    a   = '{32'h7FFFFFFF, 32'h5, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h1, 32'hF0F0F0F0, 32'h80000000,
            32'h80000000, 32'h0F0F0000, 32'hF0F0F0F0, 32'h12345678, 32'hDEADBEEF, 32'h1, 32'h5, 32'h1};
    b   = '{32'h1, 32'h7, 32'h21, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFF00FF00, 32'h24,
            32'h24, 32'h000000F0, 32'hFF00FF00, 32'hCAFEBABE, 32'h1, 32'h1, 32'h5, 32'h1F};
    r   = '{32'h80000000, 32'hFFFFFFFE, 32'h2, 32'h1, 32'h1, 32'h0, 32'h0FF00FF0, 32'h08000000,
            32'hF8000000, 32'h0F0F00F0, 32'hF000F000, 32'hCAFEBABE, 32'h0, 32'h0, 32'h0, 32'h80000000};
    for (int i = 0; i < 16; i++) begin
      issue(sel[i], a[i], b[i], r[i], 1, 1'b1);
      collect(got, lat, seen);
      e = sb_q.pop_front();
      n_checks++;
      if (!seen || got !== e.res) begin
        n_errors++;
        $display("FAIL base sel=%b a=%h b=%h: alu_out=%h expected=%h", e.sel, e.a, e.b, got, e.res);
      end
      n_checks++;
      if (lat != e.lat) begin
        n_errors++;
        $display("FAIL base latency sel=%b: %0d cycles, expected %0d", e.sel, lat, e.lat);
      end
    end
  endtask

  task automatic test_mul();
    logic [4:0]  sel[7];
    logic [31:0] a[7], b[7], r[7], got;
    int lat; bit seen; exp_t e;
    sel = '{5'b10000, 5'b10001, 5'b10011, 5'b10010, 5'b10001, 5'b10001, 5'b10000};
    a   = '{32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h40000000, 32'h80000000, 32'h10000};
    b   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4, 32'h80000000, 32'h10000};
    r   = '{32'hFFFFFFEB, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1, 32'h40000000, 32'h0};
    for (int i = 0; i < 7; i++) begin
      issue(sel[i], a[i], b[i], r[i], MLAT, 1'b1);
      if (i == 0) begin
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL mul busy flags: busy=%b in_ready=%b out_valid=%b want 1/0/0", busy, in_ready, out_valid);
        end
      end
      collect(got, lat, seen);
      e = sb_q.pop_front();
      n_checks++;
      if (!seen || got !== e.res) begin
        n_errors++;
        $display("FAIL mul sel=%b a=%h b=%h: alu_out=%h expected=%h", e.sel, e.a, e.b, got, e.res);
      end
      n_checks++;
      if (lat != e.lat) begin
        n_errors++;
        $display("FAIL mul latency sel=%b: %0d cycles, expected %0d", e.sel, lat, e.lat);
      end
    end
  endtask

  task automatic test_div();
    logic [4:0]  sel[14];
    logic [31:0] a[14], b[14], r[14], got;
    int l[14];
    int lat; bit seen; exp_t e;
    sel = '{5'b10100, 5'b10110, 5'b10101, 5'b10111, 5'b10100, 5'b10110, 5'b10100,
            5'b10110, 5'b10101, 5'b10101, 5'b10111, 5'b10100, 5'b10110, 5'b10111};
    a   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h5, 32'h5, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80000000,
            32'h80000000, 32'h80000000, 32'h64, 32'h64, 32'h7, 32'h7, 32'hFFFFFFFF};
    b   = '{32'h2, 32'h2, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'h7, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h10};
    r   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000,
            32'h0, 32'h0, 32'hE, 32'h2, 32'hFFFFFFFD, 32'h1, 32'hF};
    l   = '{MLAT, MLAT, 1, 1, 1, 1, 1, 1, MLAT, MLAT, MLAT, MLAT, MLAT, MLAT};
    for (int i = 0; i < 14; i++) begin
      issue(sel[i], a[i], b[i], r[i], l[i], 1'b1);
      collect(got, lat, seen);
      e = sb_q.pop_front();
      n_checks++;
      if (!seen || got !== e.res) begin
        n_errors++;
        $display("FAIL div sel=%b a=%h b=%h: alu_out=%h expected=%h", e.sel, e.a, e.b, got, e.res);
      end
      n_checks++;
      if (lat != e.lat) begin
        n_errors++;
        $display("FAIL div latency sel=%b a=%h b=%h: %0d cycles, expected %0d", e.sel, e.a, e.b, lat, e.lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got; int lat; bit seen; exp_t e;
    int spur = 0;
    issue(5'b00000, 32'd2, 32'd3, 32'd5, 1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; alu_sel = 5'b00001; dataA = 32'd100; dataB = 32'd1;
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || alu_out !== 32'd5 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL backpressure hold c=%0d: out_valid=%b alu_out=%h in_ready=%b busy=%b want 1/5/0/1",
                 c, out_valid, alu_out, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    collect(got, lat, seen);
    e = sb_q.pop_front();
    n_checks++;
    if (!seen || got !== e.res) begin
      n_errors++;
      $display("FAIL backpressure result: alu_out=%h expected=%h", got, e.res);
    end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_out !== 32'd5) begin
      n_errors++;
      $display("FAIL retire: out_valid=%b in_ready=%b alu_out=%h want 0/1/5", out_valid, in_ready, alu_out);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) spur++;
    end
    n_checks++;
    if (spur != 0) begin n_errors++; $display("FAIL ignored op produced output: %0d valid cycles, want 0", spur); end
  endtask

  task automatic test_flush_reset();
    logic [31:0] got; int lat; bit seen; exp_t e;
    int spur;
    issue(5'b00000, 32'd1, 32'd1, 32'd2, 1, 1'b1);
    collect(got, lat, seen);
    e = sb_q.pop_front();
    n_checks++;
    if (!seen || got !== e.res) begin n_errors++; $display("FAIL flush setup: alu_out=%h expected=%h", got, e.res); end

    issue(5'b10000, 32'd3, 32'd3, 32'd9, MLAT, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || alu_out !== 32'd2) begin
      n_errors++;
      $display("FAIL flush in BUSY: out_valid=%b in_ready=%b busy=%b alu_out=%h want 0/1/0/2",
               out_valid, in_ready, busy, alu_out);
    end
    spur = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) spur++;
    end
    n_checks++;
    if (spur != 0) begin n_errors++; $display("FAIL flushed MUL emitted: %0d valid cycles, want 0", spur); end

    flush = 1'b1;
    issue(5'b00000, 32'd7, 32'd7, 32'd14, 1, 1'b0);
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL flush vs accept: busy=%b out_valid=%b want 0/0", busy, out_valid);
    end

    issue(5'b00000, 32'd4, 32'd4, 32'd8, 1, 1'b0);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_out !== 32'd8) begin
      n_errors++;
      $display("FAIL flush vs retire: out_valid=%b in_ready=%b alu_out=%h want 0/1/8", out_valid, in_ready, alu_out);
    end

    issue(5'b10100, 32'd100, 32'd7, 32'd14, MLAT, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || alu_out !== 32'h0) begin
      n_errors++;
      $display("FAIL reset mid-DIV: in_ready=%b out_valid=%b busy=%b alu_out=%h want 1/0/0/0",
               in_ready, out_valid, busy, alu_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    spur = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) spur++;
    end
    n_checks++;
    if (spur != 0) begin n_errors++; $display("FAIL reset DIV emitted: %0d valid cycles, want 0", spur); end

    issue(5'b00000, 32'd2, 32'd3, 32'd5, 1, 1'b1);
    collect(got, lat, seen);
    e = sb_q.pop_front();
    n_checks++;
    if (!seen || got !== e.res || lat != e.lat) begin
      n_errors++;
      $display("FAIL ADD after reset: alu_out=%h lat=%0d expected %h lat %0d", got, lat, e.res, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops[4];
    logic [31:0] a, b, r, got;
    logic [63:0] p;
    int lat, k, l; bit seen; exp_t e;
    ops = '{5'b00000, 5'b00001, 5'b10011, 5'b10101};
    for (int i = 0; i < 10; i++) begin
      k = i % 4;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 0) b = 32'd1;
      p = 64'(a) * 64'(b);
      case (k)
        0:       begin r = a + b;    l = 1;    end
        1:       begin r = a - b;    l = 1;    end
        2:       begin r = p[63:32]; l = MLAT; end
        default: begin r = a / b;    l = MLAT; end
      endcase
      issue(ops[k], a, b, r, l, 1'b1);
      collect(got, lat, seen);
      e = sb_q.pop_front();
      n_checks++;
      if (!seen || got !== e.res || lat != e.lat) begin
        n_errors++;
        $display("FAIL b2b sel=%b a=%h b=%h: alu_out=%h lat=%0d expected %h lat %0d",
                 e.sel, e.a, e.b, got, lat, e.res, e.lat);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b in_ready after retire: got %b want 1", in_ready); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_base_ops();
    test_mul();
    test_div();
    test_backpressure();
    test_flush_reset();
    test_back_to_back();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard leftover: %0d entries, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
